top_sdiv_seq_24s_9ns_16: RTL and testbench

//  Inverse of the 16s x 9ns -> 24 pipelined multiplier. Sequential restoring divider:

---
 rtl/top_sdiv_seq_24s_9ns_16_if.sv | 28 ++
 rtl/top_sdiv_seq_24s_9ns_16.sv | 130 +++++++++++++
 tb/tb_top_sdiv_seq_24s_9ns_16.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/top_sdiv_seq_24s_9ns_16_if.sv
// Handshake and data bundle for the sequential signed divider top_sdiv_seq_24s_9ns_16.
// The master drives ce/start/operands; the slave (divider) returns status and results.
interface top_sdiv_seq_24s_9ns_16_if #(
    parameter int DIVIDEND_WIDTH = 24,
    parameter int DIVISOR_WIDTH  = 9,
    parameter int QUOTIENT_WIDTH = 16
);
    logic                      ce;
    logic                      start;
    logic [DIVIDEND_WIDTH-1:0] din0;
    logic [DIVISOR_WIDTH-1:0]  din1;
    logic                      busy;
    logic                      done;
    logic [QUOTIENT_WIDTH-1:0] quot;
    logic [DIVISOR_WIDTH:0]    rem;
    logic                      ovf;
    logic                      dbz;

    modport master (
        output ce, start, din0, din1,
        input  busy, done, quot, rem, ovf, dbz
    );

    modport slave (
        input  ce, start, din0, din1,
        output busy, done, quot, rem, ovf, dbz
    );
endinterface

// File: rtl/top_sdiv_seq_24s_9ns_16.sv
// Sequential restoring divider: signed 24-bit dividend / unsigned 9-bit divisor -> signed 16-bit
// quotient and signed remainder, one radix-2 step per ce cycle. Define TOP_SDIV_SAT_EN to saturate on overflow.
module top_sdiv_seq_24s_9ns_16 #(
    parameter int DIVIDEND_WIDTH = 24,
    parameter int DIVISOR_WIDTH  = 9,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    top_sdiv_seq_24s_9ns_16_if.slave    bus
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);
    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = DIVIDEND_WIDTH'(2 ** (QUOTIENT_WIDTH - 1) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = DIVIDEND_WIDTH'(2 ** (QUOTIENT_WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [DIVIDEND_WIDTH-1:0] shreg_q;     // dividend magnitude shifts out, quotient bits shift in
    logic [DIVISOR_WIDTH:0]    prem_q;
    logic [DIVISOR_WIDTH-1:0]  divisor_q;
    logic                      neg_q;
    logic                      zero_div_q;
    logic                      busy_q;
    logic                      done_q;
    logic [QUOTIENT_WIDTH-1:0] quot_q;
    logic [DIVISOR_WIDTH:0]    rem_q;
    logic                      ovf_q;
    logic                      dbz_q;

    logic [DIVISOR_WIDTH:0]    prem_shift;
    logic [DIVISOR_WIDTH:0]    prem_d;
    logic                      qbit;
    logic [DIVIDEND_WIDTH-1:0] shreg_d;
    logic [DIVIDEND_WIDTH-1:0] mag_in;
    logic [QUOTIENT_WIDTH-1:0] quot_wrap;
    logic [QUOTIENT_WIDTH-1:0] quot_sat;
    logic [QUOTIENT_WIDTH-1:0] quot_d;
    logic [DIVISOR_WIDTH:0]    rem_d;
    logic                      ovf_d;

    // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
    always_comb begin
        prem_shift = {prem_q[DIVISOR_WIDTH-1:0], shreg_q[DIVIDEND_WIDTH-1]};
        qbit       = (prem_shift >= {1'b0, divisor_q});
        prem_d     = qbit ? (prem_shift - {1'b0, divisor_q}) : prem_shift;
        shreg_d    = {shreg_q[DIVIDEND_WIDTH-2:0], qbit};

        // -2^23 negates to itself, which read as unsigned is exactly 2^23
        mag_in = bus.din0[DIVIDEND_WIDTH-1] ? (~bus.din0 + DIVIDEND_WIDTH'(1)) : bus.din0;

        quot_wrap = neg_q ? (~shreg_q[QUOTIENT_WIDTH-1:0] + QUOTIENT_WIDTH'(1))
                          : shreg_q[QUOTIENT_WIDTH-1:0];
        quot_sat  = neg_q ? {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}} : {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
        ovf_d     = neg_q ? (shreg_q > NEG_LIMIT) : (shreg_q > POS_LIMIT);
        rem_d     = neg_q ? (~prem_q + (DIVISOR_WIDTH+1)'(1)) : prem_q;
`ifdef TOP_SDIV_SAT_EN
        quot_d    = ovf_d ? quot_sat : quot_wrap;
`else
        quot_d    = quot_wrap;
`endif
        if (zero_div_q) begin
            quot_d = quot_sat;
            rem_d  = '0;
            ovf_d  = 1'b1;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            prem_q     <= '0;
            divisor_q  <= '0;
            neg_q      <= 1'b0;
            zero_div_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else if (bus.ce) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg_q    <= mag_in;
                        divisor_q  <= bus.din1;
                        neg_q      <= bus.din0[DIVIDEND_WIDTH-1];
                        zero_div_q <= (bus.din1 == '0);
                        prem_q     <= '0;
                        cnt_q      <= CW'(DIVIDEND_WIDTH - 1);
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    shreg_q <= shreg_d;
                    prem_q  <= prem_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_FIX;
                end
                S_FIX: begin
                    quot_q  <= quot_d;
                    rem_q   <= rem_d;
                    ovf_q   <= ovf_d;
                    dbz_q   <= zero_div_q;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.ovf  = ovf_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_top_sdiv_seq_24s_9ns_16.sv
// Randomized self-checking bench for top_sdiv_seq_24s_9ns_16 against an integer-arithmetic model.
// Build with +define+TOP_SDIV_SAT_EN to check the saturating variant.
module tb_top_sdiv_seq_24s_9ns_16;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    longint prev_q = 0;

    always #5 clk = ~clk;

    top_sdiv_seq_24s_9ns_16_if bus ();
    top_sdiv_seq_24s_9ns_16 dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (truncates toward zero, remainder follows dividend sign)
    function automatic void model(input logic signed [23:0] a, input logic [8:0] b,
                                  output longint q, output longint r, output longint ovf, output longint dbz);
        longint     qa;
        logic [63:0] qbits;
        if (b == 0) begin
            dbz = 1; ovf = 1; r = 0;
            q   = (a < 0) ? -32768 : 32767;
        end else begin
            dbz   = 0;
            qa    = longint'(a) / longint'(b);
            r     = longint'(a) % longint'(b);
            ovf   = (qa > 32767 || qa < -32768) ? 1 : 0;
            qbits = qa;
            q     = longint'($signed(qbits[15:0]));
`ifdef TOP_SDIV_SAT_EN
            if (ovf != 0) q = (qa < 0) ? -32768 : 32767;
`endif
        end
    endfunction

    task automatic run_op(input logic signed [23:0] a, input logic [8:0] b,
                          input int stall_at, input int stall_len, input string tag);
        longint eq, er, eo, ed;
        int     cyc;
        int     exp_lat;
        model(a, b, eq, er, eo, ed);
        exp_lat = 26 + ((stall_at > 0) ? stall_len : 0);
        @(negedge clk);
        bus.din0 = a; bus.din1 = b; bus.start = 1'b1; bus.ce = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) check({tag, ".busy_rise"}, bus.busy, 1);
            if (stall_at > 0 && cyc == stall_at) begin
                bus.ce = 1'b0;
                repeat (stall_len) @(negedge clk);
                cyc += stall_len;
                check({tag, ".stall_busy"}, bus.busy, 1);
                check({tag, ".stall_done"}, bus.done, 0);
                check({tag, ".stall_quot"}, $signed(bus.quot), prev_q);
                bus.ce = 1'b1;
            end
            if (bus.done) break;
        end
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".quot"}, $signed(bus.quot), eq);
        check({tag, ".rem"}, $signed(bus.rem), er);
        check({tag, ".ovf"}, bus.ovf, eo);
        check({tag, ".dbz"}, bus.dbz, ed);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 0);
        check({tag, ".busy_fall"}, bus.busy, 0);
        prev_q = eq;
    endtask

    initial begin
        int dones;
        logic signed [23:0] a;
        logic [8:0] b;

        reset = 1'b1; bus.ce = 1'b0; bus.start = 1'b1; bus.din0 = 24'd1000; bus.din1 = 9'd7;
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.quot", bus.quot, 0);
        check("rst.rem", bus.rem, 0);
        check("rst.ovf", bus.ovf, 0);
        check("rst.dbz", bus.dbz, 0);
        reset = 1'b0; bus.start = 1'b0; bus.ce = 1'b1;
        @(negedge clk);

        // Directed boundaries
        run_op(24'sd1000, 9'd7, 0, 0, "pos");
        run_op(-24'sd1000, 9'd7, 0, 0, "neg");
        run_op(-24'sd8388608, 9'd511, 0, 0, "minmax");
        run_op(24'sd8388607, 9'd1, 0, 0, "ovf_pos");
        run_op(-24'sd8388608, 9'd1, 0, 0, "ovf_neg");
        run_op(24'sd32767, 9'd1, 0, 0, "edge_pos");
        run_op(-24'sd32768, 9'd1, 0, 0, "edge_neg");
        run_op(24'sd32768, 9'd1, 0, 0, "edge_pos_ovf");
        run_op(-24'sd32769, 9'd1, 0, 0, "edge_neg_ovf");
        run_op(24'sd5, 9'd0, 0, 0, "dbz_pos");
        run_op(-24'sd5, 9'd0, 0, 0, "dbz_neg");
        run_op(-24'sd3, 9'd7, 0, 0, "neg_zero_q");
        run_op(24'sd1000, 9'd7, 10, 10, "stall");

        // Reset in flight: outputs clear and the aborted op never signals done
        @(negedge clk);
        bus.din0 = 24'sd1000; bus.din1 = 9'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        check("abort.quot", bus.quot, 0);
        check("abort.rem", bus.rem, 0);
        check("abort.ovf", bus.ovf, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort.no_done", dones, 0);
        prev_q = 0;

        // A start while busy is dropped: one done only, carrying the first operation's result
        @(negedge clk);
        bus.din0 = 24'sd1000; bus.din1 = 9'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.din0 = -24'sd77; bus.din1 = 9'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                check("ignore.quot", $signed(bus.quot), 142);
                check("ignore.rem", $signed(bus.rem), 6);
            end
        end
        check("ignore.one_done", dones, 1);
        prev_q = 142;

        // Randomized operands, mixing full-range and in-range dividends
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) a = 24'($urandom);
            else            a = 24'(int'($urandom_range(0, 4000000)) - 2000000);
            b = (i % 10 == 3) ? 9'd0 : 9'($urandom_range(1, 511));
            run_op(a, b, (i % 8 == 5) ? 7 : 0, 3, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
